// File: rtl/spi_master.sv
// SPI master, mode 0, byte-wide stream interface.
// Frames span bytes until tx_last_i; CS held high CS_IDLE cycles between frames.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       spi_clk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_o,
  input  logic       spi_miso_i
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT,
    HOLD
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_N = 16'(CS_IDLE);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  tx_sh_q;
  logic [7:0]  rx_sh_q;
  logic [7:0]  rx_data_q;
  logic        last_q;
  logic        sclk_q;
  logic        cs_q;
  logic        rx_vld_q;
  logic        rdy_en_q;
  logic        accept;
  logic        tick;
  logic        rise;
  logic        fall;
  logic        done;

  assign tx_ready_o = rdy_en_q &&
                      (state_q == IDLE || state_q == WAIT);
  assign accept     = tx_ready_o && tx_valid_i;
  assign tick       = (state_q == SHIFT) && (cnt_q == DIV_M1);
  assign rise       = tick && !sclk_q;
  assign fall       = tick && sclk_q;
  assign done       = fall && (bit_q == 3'd7);

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_vld_q;
  assign busy_o     = (state_q != IDLE);
  assign spi_clk_o  = sclk_q;
  assign spi_mosi_o = tx_sh_q[7];
  assign spi_cs_o   = cs_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: if (done)   state_d = last_q ? HOLD : WAIT;
      WAIT:  if (accept) state_d = SHIFT;
      HOLD:  if (cnt_q == HOLD_N) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath, SPI clock divider and chip-select timing
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      last_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      rx_vld_q  <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      rx_vld_q <= done;
      if (accept) begin
        tx_sh_q <= tx_data_i;
        last_q  <= tx_last_i;
        cs_q    <= 1'b0;
        cnt_q   <= '0;
        bit_q   <= '0;
        sclk_q  <= 1'b0;
      end else if (state_q == SHIFT) begin
        cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;
        if (rise) begin
          sclk_q  <= 1'b1;
          rx_sh_q <= {rx_sh_q[6:0], spi_miso_i};
        end
        if (fall) begin
          sclk_q <= 1'b0;
          bit_q  <= bit_q + 3'd1;
          if (!done) tx_sh_q <= {tx_sh_q[6:0], 1'b0};
        end
        if (done) rx_data_q <= rx_sh_q;
      end else if (state_q == HOLD) begin
        cs_q  <= 1'b1;
        cnt_q <= cnt_q + 16'd1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: scoreboarded loopback transfers.
// Main instance CLK_DIV=2, second instance CLK_DIV=1.
`timescale 1ns/1ps
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;

  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       cs;
  logic       miso;
  logic       force_en = 1'b0;
  logic       miso_force = 1'b0;

  logic [7:0] f_data = '0;
  logic       f_valid = 1'b0;
  logic       f_last = 1'b0;
  logic       f_ready;
  logic [7:0] f_rx_data;
  logic       f_rx_valid;
  logic       f_busy;
  logic       f_sclk;
  logic       f_mosi;
  logic       f_cs;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] q[$];
  logic [7:0] f_q[$];
  int         rise_cnt = 0;
  int         cs_hi = 0;
  int         strobe_cyc = -1;
  logic [7:0] mosi_bits = '0;
  logic       prev_sclk = 1'b0;

  assign miso = force_en ? miso_force : mosi;

  spi_master #(.CLK_DIV(2), .CS_IDLE(4)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_last_i  (tx_last),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .busy_o     (busy),
    .spi_clk_o  (sclk),
    .spi_mosi_o (mosi),
    .spi_cs_o   (cs),
    .spi_miso_i (miso)
  );

  spi_master #(.CLK_DIV(1), .CS_IDLE(4)) dut1 (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .tx_data_i  (f_data),
    .tx_valid_i (f_valid),
    .tx_last_i  (f_last),
    .tx_ready_o (f_ready),
    .rx_data_o  (f_rx_data),
    .rx_valid_o (f_rx_valid),
    .busy_o     (f_busy),
    .spi_clk_o  (f_sclk),
    .spi_mosi_o (f_mosi),
    .spi_cs_o   (f_cs),
    .spi_miso_i (f_mosi)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (sclk && !prev_sclk) begin
        rise_cnt  = rise_cnt + 1;
        mosi_bits = {mosi_bits[6:0], mosi};
      end
      prev_sclk = sclk;
      if (cs) cs_hi = cs_hi + 1;
      if (cs && sclk) begin
        vectors++;
        miscompares++;
        $display("FAIL clk_while_cs_high cyc=%0d sclk=%b cs=%b", cyc, sclk, cs);
      end
      if (rx_valid) begin
        strobe_cyc = cyc;
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rx cyc=%0d got=%h expected none", cyc, rx_data);
        end else begin
          exp = q.pop_front();
          if (rx_data !== exp) begin
            miscompares++;
            $display("FAIL rx_data cyc=%0d got=%h expected=%h", cyc, rx_data, exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l,
                      input logic [7:0] exp, input bit push,
                      input bit keep, output int t);
    t = -1;
    tx_data = d;
    tx_last = l;
    tx_valid = 1'b1;
    for (int i = 0; i < 300 && t < 0; i++) begin
      if (tx_ready) begin
        t = cyc;
        if (push) q.push_back(exp);
      end
      tick();
    end
    if (!keep) tx_valid = 1'b0;
    vectors++;
    if (t < 0) begin
      miscompares++;
      $display("FAIL send_timeout data=%h got no accept expected accept", d);
    end
  endtask

  task automatic wait_done(input int t);
    for (int i = 0; i < 200 && strobe_cyc <= t; i++) tick();
    vectors++;
    if (strobe_cyc <= t) begin
      miscompares++;
      $display("FAIL rx_strobe_timeout got none expected strobe after %0d", t);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if ({cs, sclk, mosi, tx_ready, rx_valid, busy, rx_data} !== {6'b100000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_outputs got cs=%b clk=%b mosi=%b rdy=%b rxv=%b busy=%b rx=%h expected 1 0 0 0 0 0 00",
               cs, sclk, mosi, tx_ready, rx_valid, busy, rx_data);
    end
    rst_n = 1'b1;
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge got=%b expected=0", tx_ready);
    end
    tick();
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release got=%b expected=1", tx_ready);
    end
  endtask

  task automatic test_single_byte();
    int t;
    int rb;
    int bad;
    rb = rise_cnt;
    send(8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, t);
    wait_done(t);
    vectors++;
    if (strobe_cyc != t + 33) begin
      miscompares++;
      $display("FAIL a5_strobe_cycle got=%0d expected=%0d", strobe_cyc - t, 33);
    end
    vectors++;
    if (rise_cnt - rb != 8) begin
      miscompares++;
      $display("FAIL a5_rises got=%0d expected=8", rise_cnt - rb);
    end
    vectors++;
    if (mosi_bits !== 8'hA5) begin
      miscompares++;
      $display("FAIL a5_mosi_bits got=%h expected=a5", mosi_bits);
    end
    vectors++;
    if (cs !== 1'b0) begin
      miscompares++;
      $display("FAIL a5_cs_at_strobe got=%b expected=0", cs);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (cs !== 1'b1 || sclk !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL a5_cs_hold got=%0d bad cycles expected=0", bad);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL a5_idle_after_hold got busy=%b rdy=%b expected 0 1", busy, tx_ready);
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int rb;
    int cb;
    rb = rise_cnt;
    cb = cs_hi;
    send(8'h48, 1'b0, 8'h48, 1'b1, 1'b1, t1);
    send(8'h69, 1'b1, 8'h69, 1'b1, 1'b0, t2);
    vectors++;
    if (t2 != t1 + 33) begin
      miscompares++;
      $display("FAIL b2b_second_accept got=%0d expected=33", t2 - t1);
    end
    wait_done(t2);
    vectors++;
    if (cs_hi != cb) begin
      miscompares++;
      $display("FAIL b2b_cs_gap got=%0d high cycles expected=0", cs_hi - cb);
    end
    vectors++;
    if (rise_cnt - rb != 16) begin
      miscompares++;
      $display("FAIL b2b_rises got=%0d expected=16", rise_cnt - rb);
    end
    wait_idle();
  endtask

  task automatic test_wait_gap();
    int t;
    int bad;
    send(8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0, t);
    wait_done(t);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cs !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1 || mosi !== 1'b0)
        bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL wait_state got=%0d bad cycles expected=0", bad);
    end
    send(8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0, t);
    wait_done(t);
    vectors++;
    if (mosi_bits !== 8'hC3) begin
      miscompares++;
      $display("FAIL c3_mosi_bits got=%h expected=c3", mosi_bits);
    end
    wait_idle();
  endtask

  task automatic test_miso_ones();
    int t;
    force_en = 1'b1;
    miso_force = 1'b1;
    send(8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, t);
    wait_done(t);
    vectors++;
    if (mosi_bits !== 8'h00) begin
      miscompares++;
      $display("FAIL zeros_mosi_bits got=%h expected=00", mosi_bits);
    end
    force_en = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_abort();
    int t;
    int rb;
    rb = rise_cnt;
    send(8'h96, 1'b1, 8'h00, 1'b0, 1'b0, t);
    for (int i = 0; i < 100 && rise_cnt < rb + 3; i++) tick();
    vectors++;
    if (rise_cnt < rb + 3) begin
      miscompares++;
      $display("FAIL abort_rise_timeout got=%0d expected=3", rise_cnt - rb);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (cs !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_async got cs=%b clk=%b busy=%b rdy=%b expected 1 0 0 0",
               cs, sclk, busy, tx_ready);
    end
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_ready got=%b expected=1", tx_ready);
    end
    send(8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, t);
    wait_done(t);
    vectors++;
    if (mosi_bits !== 8'h5A) begin
      miscompares++;
      $display("FAIL 5a_mosi_bits got=%h expected=5a", mosi_bits);
    end
    wait_idle();
  endtask

  task automatic test_fast_clock();
    int t;
    int rises;
    int badper;
    int strobe;
    logic prev;
    logic [7:0] exp;
    t = -1;
    f_data = 8'hFF;
    f_last = 1'b1;
    f_valid = 1'b1;
    for (int i = 0; i < 50 && t < 0; i++) begin
      if (f_ready) begin
        t = cyc;
        f_q.push_back(8'hFF);
      end
      prev = f_sclk;
      tick();
    end
    f_valid = 1'b0;
    rises = 0;
    badper = 0;
    strobe = -1;
    for (int i = 0; i < 24; i++) begin
      if (f_sclk && !prev) begin
        rises++;
        if (cyc != t + 2 * rises) badper++;
      end
      prev = f_sclk;
      if (f_rx_valid) begin
        strobe = cyc;
        vectors++;
        exp = (f_q.size() != 0) ? f_q.pop_front() : 8'hxx;
        if (f_rx_data !== exp) begin
          miscompares++;
          $display("FAIL fast_rx_data got=%h expected=%h", f_rx_data, exp);
        end
      end
      tick();
    end
    vectors++;
    if (rises != 8 || badper != 0) begin
      miscompares++;
      $display("FAIL fast_clk_edges got rises=%0d misplaced=%0d expected 8 0", rises, badper);
    end
    vectors++;
    if (strobe != t + 17) begin
      miscompares++;
      $display("FAIL fast_strobe_cycle got=%0d expected=17", strobe - t);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_wait_gap();
    test_miso_ones();
    test_reset_abort();
    test_fast_clock();
    tick();
    vectors++;
    if (q.size() != 0 || f_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", q.size() + f_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
